// File: rtl/alu_rc_pkg.sv
// Shared constants and types for the ALU result collector: flag bit positions,
// the multiply command codes and the default-width tag and FIFO entry records.
package alu_rc_pkg;

    localparam int RC_CMD_WIDTH = 4;
    localparam int RC_RES_WIDTH = 16;
    localparam int NUM_FLAGS    = 6;

    // Bit positions inside the {cout,oflow,g,l,e,err} flag vector
    localparam int FLG_ERR   = 0;
    localparam int FLG_E     = 1;
    localparam int FLG_L     = 2;
    localparam int FLG_G     = 3;
    localparam int FLG_OFLOW = 4;
    localparam int FLG_COUT  = 5;

    localparam logic [3:0] MUL_INC = 4'd9;
    localparam logic [3:0] MUL_SHL = 4'd10;

    typedef struct packed {
        logic                    vld;
        logic [RC_CMD_WIDTH-1:0] cmd;
        logic                    mode;
    } tag_t;

    typedef struct packed {
        logic [RC_RES_WIDTH-1:0] res;
        logic [NUM_FLAGS-1:0]    flags;
        logic [RC_CMD_WIDTH-1:0] cmd;
        logic                    mode;
    } entry_t;

endpackage

// File: rtl/alu_rc_fifo.sv
// First-word-fall-through FIFO of captured ALU results. A push while full only
// lands when a pop frees the head slot in the same cycle.
module alu_rc_fifo
    import alu_rc_pkg::*;
#(
    parameter int  DEPTH      = 4,
    parameter type entry_type = entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_type                  push_data,
    input  logic                       pop,
    output entry_type                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_type          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head reads as zero when empty so stale storage never shows up on the outputs
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Tracks issued ALU operations through a latency tag pipeline and captures each
// result with its flags into a FIFO drained by a ready/valid consumer.
module alu_result_collector
    import alu_rc_pkg::*;
#(
    parameter int OP_WIDTH  = 8,
    parameter int CMD_WIDTH = 4,
    parameter int RES_WIDTH = 2 * OP_WIDTH,
    parameter int ALU_LAT   = 1,
    parameter int MUL_LAT   = 2,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       mode,
    input  logic [CMD_WIDTH-1:0]       cmd,
    input  logic [1:0]                 inp_valid,
    input  logic [RES_WIDTH-1:0]       res,
    input  logic                       cout,
    input  logic                       oflow,
    input  logic                       g,
    input  logic                       l,
    input  logic                       e,
    input  logic                       err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RES_WIDTH-1:0]       out_res,
    output logic [NUM_FLAGS-1:0]       out_flags,
    output logic [CMD_WIDTH-1:0]       out_cmd,
    output logic                       out_mode,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf_sticky,
    output logic                       hzd_sticky,
    input  logic                       clr_sticky
);

    localparam int NSTG = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;

    typedef struct packed {
        logic                 vld;
        logic [CMD_WIDTH-1:0] cmd;
        logic                 mode;
    } tag_w_t;

    typedef struct packed {
        logic [RES_WIDTH-1:0] res;
        logic [NUM_FLAGS-1:0] flags;
        logic [CMD_WIDTH-1:0] cmd;
        logic                 mode;
    } entry_w_t;

    tag_w_t [NSTG-1:0] tags;
    tag_w_t [NSTG-1:0] tags_shift;
    tag_w_t [NSTG-1:0] tags_nxt;
    tag_w_t            new_tag;
    logic              issue;
    logic              issue_mul;
    logic              hzd_drop;
    logic              ovf_drop;

    logic [NUM_FLAGS-1:0] cap_flags;
    entry_w_t             cap_entry;
    entry_w_t             head;
    logic                 cap_push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign issue     = ce && (inp_valid != 2'b00);
    assign issue_mul = mode && ((cmd == CMD_WIDTH'(MUL_INC)) || (cmd == CMD_WIDTH'(MUL_SHL)));
    assign new_tag   = {1'b1, cmd, mode};

    // The tag already heading for a slot owns it; a colliding new issue is discarded
    always_comb begin
        tags_shift = '0;
        for (int i = 0; i < NSTG - 1; i++) begin
            tags_shift[i] = tags[i+1];
        end
        tags_nxt = tags_shift;
        hzd_drop = 1'b0;
        if (issue) begin
            if (issue_mul) begin
                if (tags_shift[MUL_LAT-1].vld) begin
                    hzd_drop = 1'b1;
                end else begin
                    tags_nxt[MUL_LAT-1] = new_tag;
                end
            end else begin
                if (tags_shift[ALU_LAT-1].vld) begin
                    hzd_drop = 1'b1;
                end else begin
                    tags_nxt[ALU_LAT-1] = new_tag;
                end
            end
        end
    end

    always_comb begin
        cap_flags            = '0;
        cap_flags[FLG_COUT]  = cout;
        cap_flags[FLG_OFLOW] = oflow;
        cap_flags[FLG_G]     = g;
        cap_flags[FLG_L]     = l;
        cap_flags[FLG_E]     = e;
        cap_flags[FLG_ERR]   = err;
    end

    assign cap_push  = tags[0].vld;
    assign cap_entry = {res, cap_flags, tags[0].cmd, tags[0].mode};
    assign pop       = out_valid && out_ready;
    assign ovf_drop  = cap_push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tags       <= '0;
            ovf_sticky <= 1'b0;
            hzd_sticky <= 1'b0;
        end else begin
            tags <= tags_nxt;
            if (ovf_drop) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
            if (hzd_drop) begin
                hzd_sticky <= 1'b1;
            end else if (clr_sticky) begin
                hzd_sticky <= 1'b0;
            end
        end
    end

    alu_rc_fifo #(
        .DEPTH      (DEPTH),
        .entry_type (entry_w_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_push),
        .push_data (cap_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign out_valid = !fifo_empty;
    assign out_res   = head.res;
    assign out_flags = head.flags;
    assign out_cmd   = head.cmd;
    assign out_mode  = head.mode;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed scenarios plus randomized traffic
// checked against a landing-calendar and queue model of the collector.
module tb_alu_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  cmd = 4'd0;
    logic [1:0]  inp_valid = 2'b00;
    logic [15:0] res = 16'd0;
    logic        cout = 1'b0, oflow = 1'b0, g = 1'b0, l = 1'b0, e = 1'b0, err = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_sticky = 1'b0;
    logic        out_valid;
    logic [15:0] out_res;
    logic [5:0]  out_flags;
    logic [3:0]  out_cmd;
    logic        out_mode;
    logic [2:0]  count;
    logic        ovf_sticky;
    logic        hzd_sticky;

    alu_result_collector dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .mode       (mode),
        .cmd        (cmd),
        .inp_valid  (inp_valid),
        .res        (res),
        .cout       (cout),
        .oflow      (oflow),
        .g          (g),
        .l          (l),
        .e          (e),
        .err        (err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_flags  (out_flags),
        .out_cmd    (out_cmd),
        .out_mode   (out_mode),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .hzd_sticky (hzd_sticky),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] res;
        logic [5:0]  flags;
        logic [3:0]  cmd;
        logic        mode;
    } m_entry_t;

    // Model: a calendar of which future edge each accepted op lands on, plus a result queue
    m_entry_t    mq[$];
    bit          slot_v[8];
    logic [3:0]  slot_cmd[8];
    logic        slot_mode[8];
    bit          m_ovf;
    bit          m_hzd;

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < 8; i++) slot_v[i] = 1'b0;
        m_ovf = 1'b0;
        m_hzd = 1'b0;
    endtask

    task automatic tick();
        m_entry_t ent;
        bit cap, do_pop, was_full, ovf_d, hzd_d, is_mul;
        int s, land;
        @(posedge clk);
        s = cyc % 8;
        cap = slot_v[s];
        if (cap) begin
            ent.res   = res;
            ent.flags = {cout, oflow, g, l, e, err};
            ent.cmd   = slot_cmd[s];
            ent.mode  = slot_mode[s];
            slot_v[s] = 1'b0;
        end
        hzd_d = 1'b0;
        if (ce && inp_valid != 2'b00) begin
            is_mul = mode && (cmd == 4'd9 || cmd == 4'd10);
            land = (cyc + (is_mul ? 2 : 1)) % 8;
            if (slot_v[land]) hzd_d = 1'b1;
            else begin
                slot_v[land]    = 1'b1;
                slot_cmd[land]  = cmd;
                slot_mode[land] = mode;
            end
        end
        was_full = (mq.size() == 4);
        do_pop = (mq.size() > 0) && out_ready;
        if (do_pop) void'(mq.pop_front());
        ovf_d = 1'b0;
        if (cap) begin
            if (!was_full || do_pop) mq.push_back(ent);
            else ovf_d = 1'b1;
        end
        m_ovf = ovf_d ? 1'b1 : (clr_sticky ? 1'b0 : m_ovf);
        m_hzd = hzd_d ? 1'b1 : (clr_sticky ? 1'b0 : m_hzd);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (out_res !== 16'h0) begin n_fail++; $display("FAIL reset_out_res: got %h want 0", out_res); end
        n_cmp++; if (out_flags !== 6'h0) begin n_fail++; $display("FAIL reset_out_flags: got %b want 0", out_flags); end
        n_cmp++; if (out_cmd !== 4'h0) begin n_fail++; $display("FAIL reset_out_cmd: got %h want 0", out_cmd); end
        n_cmp++; if (out_mode !== 1'b0) begin n_fail++; $display("FAIL reset_out_mode: got %b want 0", out_mode); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_sticky); end
        n_cmp++; if (hzd_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_hzd: got %b want 0", hzd_sticky); end
        rst = 1'b1;
    endtask

    task automatic test_single_add();
        mode = 1'b1; cmd = 4'd0; inp_valid = 2'b11; ce = 1'b1;
        {cout, oflow, g, l, e, err} = 6'b000010;
        tick();
        ce = 1'b0; res = 16'h0017;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_res !== 16'h0017) begin n_fail++; $display("FAIL add_out_res: got %h want 0017", out_res); end
        n_cmp++; if (out_cmd !== 4'd0) begin n_fail++; $display("FAIL add_out_cmd: got %h want 0", out_cmd); end
        n_cmp++; if (out_flags !== 6'b000010) begin n_fail++; $display("FAIL add_out_flags: got %b want 000010", out_flags); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL add_count: got %0d want 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL add_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_collision();
        mode = 1'b1; cmd = 4'd9; inp_valid = 2'b11; ce = 1'b1;
        tick();
        cmd = 4'd0;
        tick();
        ce = 1'b0; res = 16'h0042;
        tick();
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL hzd_count: got %0d want 1", count); end
        n_cmp++; if (hzd_sticky !== 1'b1) begin n_fail++; $display("FAIL hzd_sticky: got %b want 1", hzd_sticky); end
        n_cmp++; if (out_cmd !== 4'd9) begin n_fail++; $display("FAIL hzd_out_cmd: got %h want 9", out_cmd); end
        n_cmp++; if (out_res !== 16'h0042) begin n_fail++; $display("FAIL hzd_out_res: got %h want 0042", out_res); end
        clr_sticky = 1'b1; out_ready = 1'b1;
        tick();
        clr_sticky = 1'b0; out_ready = 1'b0;
        n_cmp++; if (hzd_sticky !== 1'b0) begin n_fail++; $display("FAIL hzd_clear: got %b want 0", hzd_sticky); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL hzd_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'h0102; exp_seq[1] = 16'h0103; exp_seq[2] = 16'h0104; exp_seq[3] = 16'h01AA;
        mode = 1'b1; cmd = 4'd0; inp_valid = 2'b11; out_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            ce = (j < 5);
            res = 16'h0100 + 16'(j);
            tick();
        end
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", count); end
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_sticky); end
        n_cmp++; if (out_res !== 16'h0101) begin n_fail++; $display("FAIL ovf_head: got %h want 0101", out_res); end
        ce = 1'b0; clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf_sticky); end
        ce = 1'b1;
        tick();
        ce = 1'b0; out_ready = 1'b1; res = 16'h01AA;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_pushpop_count: got %0d want 4", count); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf: got %b want 0", ovf_sticky); end
        n_cmp++; if (out_res !== 16'h0102) begin n_fail++; $display("FAIL full_pushpop_head: got %h want 0102", out_res); end
        ce = 1'b1;
        tick();
        ce = 1'b0; clr_sticky = 1'b1; res = 16'h01BB;
        tick();
        clr_sticky = 1'b0;
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_vs_drop_ovf: got %b want 1", ovf_sticky); end
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL clr_vs_drop_count: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_res !== exp_seq[k]) begin n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", k, out_res, exp_seq[k]); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
    endtask

    task automatic test_reset_midop();
        mode = 1'b1; cmd = 4'd0; inp_valid = 2'b11; ce = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        cmd = 4'd10;
        tick();
        ce = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL midop_pre_count: got %0d want 2", count); end
        #2 rst = 1'b0;
        #1;
        model_clear();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_rst_valid: got %0b want 0", out_valid); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL midop_rst_count: got %0d want 0", count); end
        @(negedge clk);
        rst = 1'b1;
        res = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL midop_post_count[%0d]: got %0d want 0", k, count); end
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_post_valid[%0d]: got %0b want 0", k, out_valid); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            ce = ($urandom_range(0, 3) != 0);
            mode = 1'($urandom);
            cmd = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 1) ? 4'd9 : 4'd10) : 4'($urandom);
            inp_valid = 2'($urandom);
            res = 16'($urandom);
            {cout, oflow, g, l, e, err} = 6'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            clr_sticky = ($urandom_range(0, 19) == 0);
            tick();
            n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid @%0d: got %0b want %0b", k, out_valid, (mq.size() > 0)); end
            n_cmp++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", k, count, mq.size()); end
            n_cmp++; if (ovf_sticky !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf @%0d: got %0b want %0b", k, ovf_sticky, m_ovf); end
            n_cmp++; if (hzd_sticky !== m_hzd) begin n_fail++; $display("FAIL rnd_hzd @%0d: got %0b want %0b", k, hzd_sticky, m_hzd); end
            if (mq.size() > 0) begin
                n_cmp++; if (out_res !== mq[0].res) begin n_fail++; $display("FAIL rnd_res @%0d: got %h want %h", k, out_res, mq[0].res); end
                n_cmp++; if (out_flags !== mq[0].flags) begin n_fail++; $display("FAIL rnd_flags @%0d: got %b want %b", k, out_flags, mq[0].flags); end
                n_cmp++; if (out_cmd !== mq[0].cmd) begin n_fail++; $display("FAIL rnd_cmd @%0d: got %h want %h", k, out_cmd, mq[0].cmd); end
                n_cmp++; if (out_mode !== mq[0].mode) begin n_fail++; $display("FAIL rnd_mode @%0d: got %b want %b", k, out_mode, mq[0].mode); end
            end
        end
        clr_sticky = 1'b0;
        ce = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_collision();
        test_overflow();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
